modulo_n_down_counter: RTL and testbench



---
 rtl/modulo_pkg.sv | 12 +
 rtl/modulo_n_down_counter.sv | 77 +++++++
 tb/tb_modulo_n_down_counter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo-N counter family.
// The state encoding and load clamp are reused by the up and down counters.
package modulo_pkg;

    typedef enum logic {ST_RUN, ST_DONE} mod_state_t;

    // The comparison is done at 32 bits, so an out-of-range load value is never truncated before it is compared.
    function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [31:0] n);
        return (val >= n) ? (n - 32'd1) : val;
    endfunction

endpackage

// File: rtl/modulo_n_down_counter.sv
// Modulo-N down counter: N-1 -> 0, then wraps (periodic) or parks in DONE (one-shot).
// One-cycle latency from load or enable to cnt/tc; all outputs are registered.
module modulo_n_down_counter
    import modulo_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         oneshot,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    if (N < 1) begin : g_bad_n
        $error("modulo_n_down_counter: N must be >= 1");
    end

    localparam logic [W-1:0] CNT_MAX = W'(N - 1);

    mod_state_t   r_state;
    logic [W-1:0] r_cnt;
    logic         r_tc;

    mod_state_t   w_state_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_tc_nxt;
    logic [W-1:0] w_load_clamped;

    assign w_load_clamped = W'(clamp_mod(32'(load_val), 32'(N)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_cnt_nxt   = w_load_clamped;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN && en) begin
            // Count 0 is handled explicitly, so the decrement below can never underflow.
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end else begin
                w_tc_nxt = 1'b1;
                if (oneshot) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = CNT_MAX;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_MAX;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_modulo_n_down_counter.sv
// Scoreboard bench: directed vectors push hand-computed expectations, and a monitor compares them after each edge.
// DUT a uses N=5 and DUT b uses N=1.
module tb_modulo_n_down_counter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_en = 1'b0, a_load = 1'b0, a_oneshot = 1'b0;
    logic [2:0] a_load_val = '0;
    logic [2:0] a_cnt;
    logic       a_tc, a_busy, a_done;

    logic       b_rst = 1'b1, b_en = 1'b0, b_load = 1'b0, b_oneshot = 1'b0;
    logic [0:0] b_load_val = '0;
    logic [0:0] b_cnt;
    logic       b_tc, b_busy, b_done;

    modulo_n_down_counter #(.N(5)) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .load_val(a_load_val),
        .oneshot(a_oneshot), .cnt(a_cnt), .tc(a_tc), .busy(a_busy), .done(a_done)
    );

    modulo_n_down_counter #(.N(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .load_val(b_load_val),
        .oneshot(b_oneshot), .cnt(b_cnt), .tc(b_tc), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        bit         sel;
        logic [2:0] cnt;
        logic       tc;
        logic       busy;
        logic       done;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;

    // Monitor: outputs settle after the edge that consumed the vector driven at the prior negedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [2:0] got_cnt;
                logic got_tc, got_busy, got_done;
                e = exp_q.pop_front();
                if (e.sel) begin
                    got_cnt = {2'b00, b_cnt}; got_tc = b_tc; got_busy = b_busy; got_done = b_done;
                end else begin
                    got_cnt = a_cnt; got_tc = a_tc; got_busy = a_busy; got_done = a_done;
                end
                n_vec++;
                if (got_cnt !== e.cnt || got_tc !== e.tc || got_busy !== e.busy || got_done !== e.done) begin
                    n_miss++;
                    $display("FAIL vec%0d dut_%s: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                             e.id, e.sel ? "n1" : "n5", got_cnt, got_tc, got_busy, got_done,
                             e.cnt, e.tc, e.busy, e.done);
                end
            end
        end
    end

    task automatic vec(input bit sel, input logic r, input logic e, input logic l,
                       input logic [2:0] lv, input logic os,
                       input logic [2:0] ec, input logic et, input logic eb, input logic ed);
        exp_t x;
        @(negedge clk);
        if (!sel) begin
            a_rst = r; a_en = e; a_load = l; a_load_val = lv; a_oneshot = os;
        end else begin
            b_rst = r; b_en = e; b_load = l; b_load_val = lv[0:0]; b_oneshot = os;
        end
        x.sel = sel; x.cnt = ec; x.tc = et; x.busy = eb; x.done = ed; x.id = vec_id;
        vec_id++;
        exp_q.push_back(x);
    endtask

    initial begin
        // Periodic counting: reset to 4, then wrap with tc on each 0 -> 4.
        vec(0, 1,0,0,0,0, 4,0,1,0);
        vec(0, 1,0,0,0,0, 4,0,1,0);
        vec(0, 0,1,0,0,0, 3,0,1,0);
        vec(0, 0,1,0,0,0, 2,0,1,0);
        vec(0, 0,1,0,0,0, 1,0,1,0);
        vec(0, 0,1,0,0,0, 0,0,1,0);
        vec(0, 0,1,0,0,0, 4,1,1,0);
        vec(0, 0,1,0,0,0, 3,0,1,0);
        vec(0, 0,1,0,0,0, 2,0,1,0);
        vec(0, 0,1,0,0,0, 1,0,1,0);
        vec(0, 0,1,0,0,0, 0,0,1,0);
        vec(0, 0,1,0,0,0, 4,1,1,0);
        vec(0, 0,1,0,0,0, 3,0,1,0);
        vec(0, 0,1,0,0,0, 2,0,1,0);
        // One-shot: reset mid-count, count down, park in DONE, then ignore en.
        vec(0, 1,1,0,0,1, 4,0,1,0);
        vec(0, 0,1,0,0,1, 3,0,1,0);
        vec(0, 0,1,0,0,1, 2,0,1,0);
        vec(0, 0,1,0,0,1, 1,0,1,0);
        vec(0, 0,1,0,0,1, 0,0,1,0);
        vec(0, 0,1,0,0,1, 0,1,0,1);
        vec(0, 0,0,0,0,1, 0,0,0,1);
        vec(0, 0,1,0,0,1, 0,0,0,1);
        vec(0, 0,1,0,0,0, 0,0,0,1);
        // Load of 2 from DONE, then count 1, 0 and re-enter DONE with one tc.
        vec(0, 0,0,1,2,1, 2,0,1,0);
        vec(0, 0,1,0,0,1, 1,0,1,0);
        vec(0, 0,1,0,0,1, 0,0,1,0);
        vec(0, 0,1,0,0,1, 0,1,0,1);
        vec(0, 0,1,0,0,1, 0,0,0,1);
        // Clamp: 7 and 5 both load as 4. Load wins over en when cnt is 0.
        vec(0, 0,0,1,7,0, 4,0,1,0);
        vec(0, 0,1,1,5,0, 4,0,1,0);
        vec(0, 0,1,0,0,0, 3,0,1,0);
        vec(0, 0,1,0,0,0, 2,0,1,0);
        vec(0, 0,1,0,0,0, 1,0,1,0);
        vec(0, 0,1,0,0,0, 0,0,1,0);
        vec(0, 0,1,1,3,0, 3,0,1,0);
        vec(0, 0,0,0,0,0, 3,0,1,0);
        vec(0, 0,1,0,0,0, 2,0,1,0);
        // rst beats load when both are asserted mid-count.
        vec(0, 1,1,1,1,0, 4,0,1,0);
        // Loading 0 followed by an enabled edge gives back-to-back activity; en=0 clears tc.
        vec(0, 0,1,1,0,0, 0,0,1,0);
        vec(0, 0,1,0,0,0, 4,1,1,0);
        vec(0, 0,0,0,0,0, 4,0,1,0);
        // oneshot sampled only on the edge that consumes 0.
        vec(0, 0,1,1,1,1, 1,0,1,0);
        vec(0, 0,1,0,0,0, 0,0,1,0);
        vec(0, 0,1,0,0,0, 4,1,1,0);
        // N=1: tc on every enabled edge, falls when en drops, and one-shot goes to DONE.
        vec(1, 1,0,0,0,0, 0,0,1,0);
        vec(1, 0,1,0,0,0, 0,1,1,0);
        vec(1, 0,1,0,0,0, 0,1,1,0);
        vec(1, 0,1,0,0,0, 0,1,1,0);
        vec(1, 0,0,0,0,0, 0,0,1,0);
        vec(1, 0,1,0,0,1, 0,1,0,1);
        vec(1, 0,1,0,0,1, 0,0,0,1);
        vec(1, 0,0,1,1,1, 0,0,1,0);
        vec(1, 1,0,0,0,0, 0,0,1,0);

        @(negedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
